// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg: shared limits, defaults and flag encoding for the GPIO input conditioner.
package gpio_cond_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PRESC_W_DEF = 16;
  localparam int CNT_W_DEF = 4;
  localparam int FLAG_RISE = 0;
  localparam int FLAG_FALL = 1;
  localparam int FLAG_W = 2;
  typedef logic [FLAG_W-1:0] flags_t;
  function automatic int clamp_sync(int n);
    return n < SYNC_STAGES_MIN ? SYNC_STAGES_MIN : n > SYNC_STAGES_MAX ? SYNC_STAGES_MAX : n;
  endfunction
endpackage

// File: rtl/gpio_debounce_cell.sv
// gpio_debounce_cell: per-channel synchronizer, tick-based debounce counter, clean level and sticky edge flags.
module gpio_debounce_cell
  import gpio_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw,
  input  logic             tick,
  input  logic [CNT_W-1:0] deb_thr,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             flag_ack,
  output logic             clean,
  output flags_t           flags
);
  logic [SYNC_STAGES-1:0] sr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic sync, bypass, differ, reached, clean_nxt;
  flags_t set;
  assign sync = sr[SYNC_STAGES-1];
  assign bypass = deb_thr == '0;
  assign differ = sync != clean;
  // compare one bit wider so cnt+1 cannot wrap before reaching the threshold
  assign reached = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, deb_thr};
  always_comb begin
    clean_nxt = bypass ? sync : (tick && differ && reached) ? sync : clean;
    cnt_nxt = (bypass || !differ || (tick && reached)) ? '0 :
              (tick && cnt != '1) ? cnt + CNT_W'(1) : cnt;
    set = '0;
    set[FLAG_RISE] = rise_en & ~clean & clean_nxt;
    set[FLAG_FALL] = fall_en & clean & ~clean_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
      cnt <= '0;
      clean <= 1'b0;
      flags <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], raw};
      cnt <= cnt_nxt;
      clean <= clean_nxt;
      flags <= set | (flags & ~{FLAG_W{flag_ack}});
    end
  end
endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: shared prescaler, NR_IOS debounce cells and a registered interrupt.
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int NR_IOS = 32,
  parameter int SYNC_STAGES = 2,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR_IOS-1:0]  raw_in,
  input  logic [PRESC_W-1:0] presc_val,
  input  logic [CNT_W-1:0]   deb_thr,
  input  logic [NR_IOS-1:0]  rise_en,
  input  logic [NR_IOS-1:0]  fall_en,
  input  logic [NR_IOS-1:0]  flag_ack,
  output logic [NR_IOS-1:0]  clean_out,
  output logic [NR_IOS-1:0]  rise_flag,
  output logic [NR_IOS-1:0]  fall_flag,
  output logic               irq
);
  localparam int SYNC_N = clamp_sync(SYNC_STAGES);
  logic [PRESC_W-1:0] pc;
  logic tick;
  flags_t fl [NR_IOS];
  // >= rather than == so a lowered presc_val ticks at once instead of wrapping
  assign tick = pc >= presc_val;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      irq <= 1'b0;
    end else begin
      pc <= tick ? '0 : pc + PRESC_W'(1);
      irq <= |(rise_flag | fall_flag);
    end
  end
  for (genvar i = 0; i < NR_IOS; i++) begin : g_ch
    gpio_debounce_cell #(.SYNC_STAGES(SYNC_N), .CNT_W(CNT_W)) u_cell (
      .clk(clk),
      .rst(rst),
      .raw(raw_in[i]),
      .tick(tick),
      .deb_thr(deb_thr),
      .rise_en(rise_en[i]),
      .fall_en(fall_en[i]),
      .flag_ack(flag_ack[i]),
      .clean(clean_out[i]),
      .flags(fl[i])
    );
    assign rise_flag[i] = fl[i][FLAG_RISE];
    assign fall_flag[i] = fl[i][FLAG_FALL];
  end
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: scoreboard bench; expectations are queued with a due cycle and checked at negedge.
module tb_gpio_in_conditioner;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] raw_in = '0, rise_en = '0, fall_en = '0, flag_ack = '0;
  logic [15:0] presc_val = '0;
  logic [3:0] deb_thr = '0;
  logic [N-1:0] clean_out, rise_flag, fall_flag;
  logic irq;
  gpio_in_conditioner #(.NR_IOS(N), .SYNC_STAGES(2), .PRESC_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .presc_val(presc_val), .deb_thr(deb_thr),
    .rise_en(rise_en), .fall_en(fall_en), .flag_ack(flag_ack),
    .clean_out(clean_out), .rise_flag(rise_flag), .fall_flag(fall_flag), .irq(irq)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int at;
    string tag;
    int sel;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];
  int errs = 0;
  int checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return 32'(clean_out);
      1: return 32'(rise_flag);
      2: return 32'(fall_flag);
      3: return 32'(irq);
      4: return 32'(dut.pc);
      default: return 32'(dut.tick);
    endcase
  endfunction
  task automatic exp_at(input string tag, input int sel, input int dly, input logic [31:0] v);
    sb.push_back('{cyc + dly, tag, sel, v});
  endtask
  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, obs(sb[i].sel), sb[i].v);
        sb.delete(i);
      end
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
  endtask
  initial begin
    rise_en = '1;
    fall_en = '1;
    tick_n(2);
    chk("rst_clean", 32'(clean_out), 0);
    chk("rst_rise", 32'(rise_flag), 0);
    chk("rst_fall", 32'(fall_flag), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_pc", 32'(dut.pc), 0);
    rst = 1'b0;
    // bypass: latency SYNC_STAGES+1, irq one cycle after flag
    tick_n(5);
    raw_in[0] = 1'b1;
    exp_at("byp_clean_early", 0, 2, 0);
    exp_at("byp_clean", 0, 3, 1);
    exp_at("byp_rise", 1, 3, 1);
    exp_at("byp_irq_lag", 3, 3, 0);
    exp_at("byp_irq", 3, 4, 1);
    tick_n(5);
    flag_ack = '1;
    tick_n(1);
    flag_ack = '0;
    exp_at("byp_ack", 1, 0, 0);
    exp_at("byp_ack_irq", 3, 1, 0);
    raw_in[0] = 1'b0;
    exp_at("byp_clean0", 0, 3, 0);
    exp_at("byp_fall", 2, 3, 1);
    tick_n(6);
    flag_ack = '1;
    tick_n(1);
    flag_ack = '0;
    // debounce: presc 9, thr 3, ticks land at r+10k
    presc_val = 9;
    deb_thr = 3;
    tick_n(2);
    do_reset();
    raw_in[1] = 1'b1;
    exp_at("deb_mid", 0, 20, 0);
    exp_at("deb_before", 0, 29, 0);
    exp_at("deb_rise", 0, 30, 2);
    exp_at("deb_rflag", 1, 30, 2);
    tick_n(32);
    flag_ack = '1;
    tick_n(1);
    flag_ack = '0;
    tick_n(8);
    raw_in[1] = 1'b0;
    tick_n(25);
    raw_in[1] = 1'b1;
    exp_at("glitch_hold", 0, 4, 2);
    exp_at("glitch_nofall", 2, 4, 0);
    tick_n(15);
    raw_in[1] = 1'b0;
    exp_at("glitch2_mid", 0, 10, 2);
    tick_n(25);
    raw_in[1] = 1'b1;
    exp_at("glitch2_hold", 0, 4, 2);
    tick_n(6);
    // ack race on channel 2 in bypass
    presc_val = 0;
    deb_thr = 0;
    do_reset();
    raw_in = 8'h04;
    tick_n(2);
    flag_ack = 8'h04;
    tick_n(1);
    flag_ack = 8'h04;
    exp_at("race_rise", 1, 0, 4);
    exp_at("race_irq", 3, 1, 1);
    tick_n(1);
    flag_ack = '0;
    exp_at("race_ack", 1, 0, 0);
    exp_at("race_irq_drop", 3, 1, 0);
    tick_n(4);
    // prescaler shrink below current pc
    presc_val = 200;
    do_reset();
    tick_n(100);
    exp_at("pc100", 4, 0, 100);
    presc_val = 50;
    exp_at("tick_now", 5, 0, 1);
    exp_at("pc0", 4, 1, 0);
    exp_at("tick_off", 5, 1, 0);
    exp_at("tick_early", 5, 50, 0);
    exp_at("tick_p51", 5, 51, 1);
    exp_at("pc_restart", 4, 52, 0);
    tick_n(53);
    // reset mid-debounce with flags set
    presc_val = 9;
    deb_thr = 3;
    do_reset();
    raw_in = 8'h01;
    exp_at("rm_clean0", 0, 30, 1);
    tick_n(31);
    raw_in = 8'h09;
    exp_at("rm_flags_set", 1, 23, 1);
    exp_at("rm_irq_set", 3, 23, 1);
    tick_n(24);
    rst = 1'b1;
    #1;
    chk("rm_async_clean", 32'(clean_out), 0);
    chk("rm_async_rise", 32'(rise_flag), 0);
    chk("rm_async_irq", 32'(irq), 0);
    tick_n(2);
    rst = 1'b0;
    exp_at("rm_noflag", 1, 1, 0);
    exp_at("rm_mid", 0, 20, 0);
    exp_at("rm_pre", 0, 29, 0);
    exp_at("rm_full", 0, 30, 9);
    tick_n(32);
    flag_ack = '1;
    tick_n(1);
    flag_ack = '0;
    // masking: falls disabled, rise flags survive enable removal
    presc_val = 0;
    deb_thr = 0;
    fall_en = '0;
    rise_en = '1;
    raw_in = '0;
    do_reset();
    raw_in = '1;
    exp_at("mask_clean1", 0, 3, 8'hFF);
    exp_at("mask_rise", 1, 3, 8'hFF);
    tick_n(5);
    rise_en = '0;
    raw_in = '0;
    exp_at("mask_clean0", 0, 3, 0);
    exp_at("mask_nofall", 2, 4, 0);
    exp_at("mask_rise_kept", 1, 4, 8'hFF);
    tick_n(6);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
